// File: rtl/functional_unit_tester.sv
// functional_unit_tester: replays a table of (X, expected Yin) vectors into a
// functional unit and reports pass/fail, first failing index and mismatch count.
// Optional build macro FUT_STOP_ON_FAIL_EN: end the run on the first mismatch.
//
// fu_x is registered, so the vector on fu_x during a cycle is the one whose
// Yin shows up at the next posedge (the unit updates on negedge). Each RUN/LAST
// edge therefore checks the vector currently on fu_x and issues the next one.
module functional_unit_tester #(
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          TLR_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [3:0]    wr_x,
    input  logic [3:0]    wr_exp,
    input  logic [AW:0]   len,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [AW:0]   err_cnt,
    output logic [AW-1:0] fail_idx,
    output logic [3:0]    fail_got,
    output logic          fu_tlr,
    output logic [3:0]    fu_x,
    input  logic [3:0]    fu_yin
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RST  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] LAST = 2'd3;

    localparam logic [AW:0]   DEPTH_V = DEPTH[AW:0];
    localparam logic [AW:0]   ONE_W   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_I   = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [AW-1:0] cur;       // index of the vector currently on fu_x
    logic [AW:0]   len_eff;   // clamped run length
    logic [3:0]    tab_x   [DEPTH];
    logic [3:0]    tab_exp [DEPTH];

    logic [AW-1:0] nxt;
    logic          cmp_en;
    logic          miss;
    logic [AW:0]   err_inc;

    assign busy    = (state != IDLE);
    assign fu_tlr  = (state == RST);
    assign nxt     = cur + ONE_I;
    assign cmp_en  = (state == RUN) || (state == LAST);
    assign miss    = cmp_en && (fu_yin != tab_exp[cur]);
    assign err_inc = (err_cnt == DEPTH_V) ? err_cnt : err_cnt + ONE_W;

    // Vector table: writable only while idle, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            tab_x[wr_addr]   <= wr_x;
            tab_exp[wr_addr] <= wr_exp;
        end
    end

    // Run sequencer: launch, reset the unit, issue/compare, report
    always_ff @(posedge clk or negedge TLR_n) begin
        if (!TLR_n) begin
            state    <= IDLE;
            cur      <= '0;
            len_eff  <= '0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_idx <= '0;
            fail_got <= '0;
            fu_x     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    fu_x <= '0;
                    if (start && len != '0) begin
                        state    <= RST;
                        len_eff  <= (len > DEPTH_V) ? DEPTH_V : len;
                        err_cnt  <= '0;
                        pass     <= 1'b0;
                        fail_idx <= '0;
                        fail_got <= '0;
                    end
                end
                RST: begin
                    cur   <= '0;
                    fu_x  <= tab_x[0];
                    state <= (len_eff == ONE_W) ? LAST : RUN;
                end
                default: begin
                    if (miss) begin
                        err_cnt <= err_inc;
                        if (err_cnt == '0) begin
                            fail_idx <= cur;
                            fail_got <= fu_yin;
                        end
                    end
`ifdef FUT_STOP_ON_FAIL_EN
                    if (miss || state == LAST) begin
`else
                    if (state == LAST) begin
`endif
                        state <= IDLE;
                        fu_x  <= '0;
                        done  <= 1'b1;
                        pass  <= !miss && (err_cnt == '0);
                    end else begin
                        cur  <= nxt;
                        fu_x <= tab_x[nxt];
                        if ({1'b0, nxt} == len_eff - ONE_W)
                            state <= LAST;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_functional_unit_tester.sv
// Bench for functional_unit_tester with a behavioural functional unit:
// on negedge, TLR forces Yin=3, otherwise Yin <= X ^ (5*Yin + 4) mod 16.
module tb_functional_unit_tester;
    logic       clk = 1'b0;
    logic       TLR_n;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_x;
    logic [3:0] wr_exp;
    logic [4:0] len;
    logic       start;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [3:0] fail_idx, fail_got;
    logic       fu_tlr;
    logic [3:0] fu_x;
    logic [3:0] fu_state = 4'h0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] tx [16];
    logic [3:0] te [16];

    functional_unit_tester #(.AW(4), .DEPTH(16)) dut (
        .clk(clk), .TLR_n(TLR_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_exp(wr_exp), .len(len), .start(start),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_idx(fail_idx), .fail_got(fail_got), .fu_tlr(fu_tlr),
        .fu_x(fu_x), .fu_yin(fu_state)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] fu_next(input logic [3:0] y, input logic [3:0] x);
        int t;
        t = int'(y) * 5 + 4;
        return x ^ t[3:0];
    endfunction

    // Functional unit under test: state updates on negedge
    always @(negedge clk) begin
        if (fu_tlr) fu_state <= 4'h3;
        else        fu_state <= fu_next(fu_state, fu_x);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [3:0] x, input logic [3:0] e);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_x = x; wr_exp = e;
        tick();
        wr_en = 1'b0;
        tx[a] = x;
        te[a] = e;
    endtask

    // Expected outcome of a run: walk the unit's state over the table
    task automatic model(input int ln, output int n_err, output int f_idx,
                         output int f_got, output int n_cyc);
        int n;
        logic [3:0] y;
        n = (ln > 16) ? 16 : ln;
        y = 4'h3;
        n_err = 0; f_idx = 0; f_got = 0; n_cyc = n + 1;
        for (int i = 0; i < n; i++) begin
            y = fu_next(y, tx[i]);
            if (y != te[i]) begin
                if (n_err == 0) begin
                    f_idx = i;
                    f_got = int'(y);
                end
                if (n_err < 16) n_err++;
`ifdef FUT_STOP_ON_FAIL_EN
                n_cyc = i + 2;
                break;
`endif
            end
        end
    endtask

    // Launch a run; optionally poke a write and a restart while busy
    task automatic run(input int ln, input string tag, input bit poke);
        int e_err, e_idx, e_got, e_cyc, cyc;
        model(ln, e_err, e_idx, e_got, e_cyc);
        len = ln[4:0];
        start = 1'b1;
        tick();                      // P0
        start = 1'b0;
        chk({tag, ":tlr"}, 32'(fu_tlr), 1);
        chk({tag, ":busy"}, 32'(busy), 1);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                chk({tag, ":x0"}, 32'(fu_x), 32'(tx[0]));
                if (poke) begin
                    wr_en = 1'b1; wr_addr = 4'd3; wr_x = 4'hF; wr_exp = 4'hF;
                    start = 1'b1; len = 5'd1;
                end
            end
            if (cyc == 2 && poke) begin
                wr_en = 1'b0; start = 1'b0; len = ln[4:0];
            end
        end
        chk({tag, ":done_cyc"}, cyc, e_cyc);
        chk({tag, ":pass"}, 32'(pass), (e_err == 0) ? 1 : 0);
        chk({tag, ":err_cnt"}, 32'(err_cnt), e_err);
        if (e_err != 0) begin
            chk({tag, ":fail_idx"}, 32'(fail_idx), e_idx);
            chk({tag, ":fail_got"}, 32'(fail_got), e_got);
        end
        chk({tag, ":busy_end"}, 32'(busy), 0);
        chk({tag, ":x_end"}, 32'(fu_x), 0);
        tick();
        chk({tag, ":done_pulse"}, 32'(done), 0);
    endtask

    task automatic load_ref(input bit bad2);
        load(0, 4'h2, 4'h1);
        load(1, 4'h2, 4'hB);
        load(2, 4'hA, bad2 ? 4'hC : 4'h1);
        load(3, 4'hA, 4'h3);
    endtask

    initial begin
        logic [3:0] y, x, e;
        TLR_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_exp = '0;
        len = '0; start = 1'b0;
        #2;
        chk("rst:busy", 32'(busy), 0);
        chk("rst:done", 32'(done), 0);
        chk("rst:pass", 32'(pass), 0);
        chk("rst:err_cnt", 32'(err_cnt), 0);
        chk("rst:fail_idx", 32'(fail_idx), 0);
        chk("rst:fail_got", 32'(fail_got), 0);
        chk("rst:fu_tlr", 32'(fu_tlr), 0);
        chk("rst:fu_x", 32'(fu_x), 0);
        tick(); tick();
        TLR_n = 1'b1;
        tick();

        // Reference sequence and injected mismatch
        load_ref(1'b0);
        run(4, "good", 1'b0);
        load_ref(1'b1);
        run(4, "inject", 1'b0);

        // len=0 is ignored
        load_ref(1'b0);
        len = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("len0:busy", 32'(busy), 0);
            chk("len0:done", 32'(done), 0);
            tick();
        end

        // Full table, len clamped from 31
        y = 4'h3;
        for (int i = 0; i < 16; i++) begin
            x = 4'($urandom_range(0, 15));
            y = fu_next(y, x);
            load(i, x, y);
        end
        run(31, "len31", 1'b0);

        // Writes and start while busy must be ignored
        load_ref(1'b0);
        run(4, "poke", 1'b1);
        run(4, "poke_after", 1'b0);

        // Mid-run reset
        len = 5'd4; start = 1'b1;
        tick();                      // P0
        start = 1'b0;
        tick(); tick();              // P2
        TLR_n = 1'b0;
        #1;
        chk("mid:busy", 32'(busy), 0);
        chk("mid:done", 32'(done), 0);
        chk("mid:err_cnt", 32'(err_cnt), 0);
        chk("mid:fu_tlr", 32'(fu_tlr), 0);
        chk("mid:fu_x", 32'(fu_x), 0);
        chk("mid:pass", 32'(pass), 0);
        tick();
        TLR_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid:no_done", 32'(done), 0);
        end
        run(4, "post_rst", 1'b0);

        // Randomized tables with occasional corrupted expectations
        for (int it = 0; it < 25; it++) begin
            y = 4'h3;
            for (int i = 0; i < 16; i++) begin
                x = 4'($urandom_range(0, 15));
                y = fu_next(y, x);
                e = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : y;
                load(i, x, e);
            end
            run(int'($urandom_range(1, 31)), "rnd", 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
